rv_mem_seq: RTL and testbench

RV_MEM_SEQ -- requirements
Module: rv_mem_seq

---
 rtl/rv_mem_seq_pkg.sv | 19 +
 rtl/rv_mem_seq.sv | 135 +++++++++++++
 tb/tb_rv_mem_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mem_seq_pkg.sv
// Shared types and constants for the single-port multi-cycle memory sequencer.
package rv_mem_seq_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 30;
    localparam int INSTRET_W = 64;

    localparam logic [ADDR_W-1:0] RESET_PC = 30'h0;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        DATA_RD,
        LD_COMMIT,
        DATA_WR,
        HALTED
    } state_t;

endpackage

// File: rtl/rv_mem_seq.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch and data access.
// Define RV_MEM_SEQ_INSTRET_EN to add the 64-bit retired-instruction counter output.
module rv_mem_seq
    import rv_mem_seq_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_W-1:0]    core_pc,
    output logic [DATA_W-1:0]    core_inst,
    output logic [DATA_W-1:0]    core_ram_load_value,
    input  logic                 core_halt,
    input  logic                 core_ram_load,
    input  logic                 core_ram_store,
    input  logic [ADDR_W-1:0]    core_ram_address,
    input  logic [DATA_W-1:0]    core_ram_store_value,
    input  logic [ADDR_W-1:0]    core_pcnext,
    output logic                 core_commit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 halted
`ifdef RV_MEM_SEQ_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [DATA_W-1:0]   ir, ir_n;
    logic [DATA_W-1:0]   dr, dr_n;
    // Cleared by reset so the first cycle out of reset issues no request
    // and a late mem_ready from an abandoned access cannot be taken.
    logic                active;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            dr     <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            dr     <= dr_n;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        dr_n        = dr;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc;
        mem_wdata   = '0;
        core_commit = 1'b0;
        case (state)
            FETCH: begin
                if (active) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_n    = mem_rdata;
                        state_n = EXEC;
                    end
                end
            end
            EXEC: begin
                if (core_halt) begin
                    state_n = HALTED;
                end else if (core_ram_load || core_ram_store) begin
                    state_n = DATA_RD;
                end else begin
                    core_commit = 1'b1;
                    pc_n        = core_pcnext;
                    state_n     = FETCH;
                end
            end
            DATA_RD: begin
                mem_req  = 1'b1;
                mem_addr = core_ram_address;
                if (mem_ready) begin
                    dr_n    = mem_rdata;
                    state_n = core_ram_load ? LD_COMMIT : DATA_WR;
                end
            end
            // Extra cycle so the core sees the freshly loaded DR when it commits.
            LD_COMMIT: begin
                core_commit = 1'b1;
                pc_n        = core_pcnext;
                state_n     = FETCH;
            end
            DATA_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = core_ram_address;
                mem_wdata = core_ram_store_value;
                if (mem_ready) begin
                    core_commit = 1'b1;
                    pc_n        = core_pcnext;
                    state_n     = FETCH;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign core_pc             = pc;
    assign core_inst           = ir;
    assign core_ram_load_value = dr;
    assign halted              = (state == HALTED);

`ifdef RV_MEM_SEQ_INSTRET_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            instret <= '0;
        end else if (core_commit) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_mem_seq.sv
// Scoreboard bench for rv_mem_seq: a toy core, a wait-state memory and an instruction-level reference model.
module tb_rv_mem_seq;

    localparam logic [31:0] HALT_INST = 32'h00100073;
    localparam logic [31:0] NOP_INST  = 32'h00000013;
    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_JAL    = 7'h6F;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] core_pc;
    logic [31:0] core_inst;
    logic [31:0] core_ram_load_value;
    logic        core_halt;
    logic        core_ram_load;
    logic        core_ram_store;
    logic [29:0] core_ram_address;
    logic [31:0] core_ram_store_value;
    logic [29:0] core_pcnext;
    logic        core_commit;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        halted;
`ifdef RV_MEM_SEQ_INSTRET_EN
    logic [63:0] instret;
`endif

    typedef struct {
        logic [29:0] pc;
        logic [31:0] inst;
        logic [31:0] dr;
        logic        st;
        logic [29:0] st_addr;
        logic [31:0] st_data;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    int          total = 0;
    int          bad = 0;
    logic        hold = 1'b0;
    logic        ready_ovr = 1'b0;
    logic        wait_mode = 1'b0;
    int          wait_cnt = 0;
    logic        rst_seen = 1'b0;
    int          since = 0;
    logic        pend = 1'b0;
    logic [29:0] p_addr = '0;
    logic        p_we = 1'b0;
    logic [31:0] p_wdata = '0;

    always #5 clock = ~clock;

    rv_mem_seq dut (
        .clock               (clock),
        .reset               (reset),
        .core_pc             (core_pc),
        .core_inst           (core_inst),
        .core_ram_load_value (core_ram_load_value),
        .core_halt           (core_halt),
        .core_ram_load       (core_ram_load),
        .core_ram_store      (core_ram_store),
        .core_ram_address    (core_ram_address),
        .core_ram_store_value(core_ram_store_value),
        .core_pcnext         (core_pcnext),
        .core_commit         (core_commit),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ready           (mem_ready),
        .mem_rdata           (mem_rdata),
        .halted              (halted)
`ifdef RV_MEM_SEQ_INSTRET_EN
        ,
        .instret             (instret)
`endif
    );

    // Toy ISA: loads/stores use RV immediates off x0; jal jumps by a signed 8-bit word offset.
    function automatic logic [31:0] f_byteaddr(input logic [31:0] inst);
        logic [11:0] imm;
        imm = (inst[6:0] == OP_STORE) ? {inst[31:25], inst[11:7]} : inst[31:20];
        return {{20{imm[11]}}, imm};
    endfunction

    function automatic logic [29:0] f_ea(input logic [31:0] inst);
        logic [31:0] b;
        b = f_byteaddr(inst);
        return b[31:2];
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] dr, input logic [31:0] inst);
        logic [31:0] b;
        logic [31:0] r;
        b = f_byteaddr(inst);
        r = dr;
        r[{b[1:0], 3'b000} +: 8] = {3'b000, inst[24:20]};
        return r;
    endfunction

    function automatic logic [29:0] f_next(input logic [29:0] pc, input logic [31:0] inst);
        if (inst[6:0] == OP_JAL) return pc + {{22{inst[31]}}, inst[31:24]};
        return pc + 30'd1;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case (r[1:0])
            2'd0:    return {r[31:7], 7'h13};
            2'd1:    return {r[31:7], OP_JAL};
            2'd2:    return {r[31:7], OP_LOAD};
            default: return {r[31:7], OP_STORE};
        endcase
    endfunction

    always_comb begin
        core_halt            = (core_inst == HALT_INST);
        core_ram_load        = (core_inst[6:0] == OP_LOAD);
        core_ram_store       = (core_inst[6:0] == OP_STORE);
        core_ram_address     = f_ea(core_inst);
        core_pcnext          = f_next(core_pc, core_inst);
        core_ram_store_value = f_merge(core_ram_load_value, core_inst);
    end

    assign mem_ready = ready_ovr | (mem_req & ~hold & (wait_cnt == 0));

    always_comb begin
        mem_rdata = mem[mem_addr[9:0]];
    end

    always @(posedge clock) begin
        rst_seen <= reset;
        if (!reset) begin
            wait_cnt <= 0;
        end else if (mem_req && mem_ready) begin
            wait_cnt <= wait_mode ? int'($urandom_range(0, 3)) : 0;
        end else if (mem_req && wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Monitor: pops the scoreboard on every commit, checks request stability, performs memory writes.
    always @(negedge clock) begin
        if (!rst_seen) since = 0;
        else since++;
        if (core_commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit: commit at pc=%0h expected none", core_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_pc", 64'(core_pc), 64'(mon_e.pc));
                chk("commit_inst", 64'(core_inst), 64'(mon_e.inst));
                chk("commit_dr", 64'(core_ram_load_value), 64'(mon_e.dr));
                if (mon_e.st) begin
                    chk("store_strobe", 64'(mem_req & mem_we & mem_ready), 64'd1);
                    chk("store_addr", 64'(mem_addr), 64'(mon_e.st_addr));
                    chk("store_data", 64'(mem_wdata), 64'(mon_e.st_data));
                end
                if (mon_e.lat != 0) chk("latency", 64'(since), 64'(mon_e.lat));
            end
            since = 0;
        end
        if (pend && rst_seen) begin
            chk("req_held", 64'(mem_req), 64'd1);
            chk("addr_stable", 64'(mem_addr), 64'(p_addr));
            chk("we_stable", 64'(mem_we), 64'(p_we));
            chk("wdata_stable", 64'(mem_wdata), 64'(p_wdata));
        end
        pend    = (mem_req === 1'b1) && (mem_ready === 1'b0);
        p_addr  = mem_addr;
        p_we    = mem_we;
        p_wdata = mem_wdata;
        if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) mem[mem_addr[9:0]] = mem_wdata;
    end

    // Instruction-level reference: walks the program from pc 0 and queues one record per retirement.
    task automatic build_expect(input int n, input bit check_lat);
        logic [29:0] pc;
        logic [31:0] dr;
        logic [31:0] inst;
        logic [29:0] a;
        exp_t        e;
        pc = '0;
        dr = '0;
        ref_mem = mem;
        for (int i = 0; i < n; i++) begin
            inst      = ref_mem[pc[9:0]];
            a         = f_ea(inst);
            e.pc      = pc;
            e.inst    = inst;
            e.st      = 1'b0;
            e.st_addr = '0;
            e.st_data = '0;
            e.lat     = 2;
            if (inst[6:0] == OP_LOAD) begin
                dr    = ref_mem[a[9:0]];
                e.lat = 4;
            end else if (inst[6:0] == OP_STORE) begin
                dr               = ref_mem[a[9:0]];
                e.st             = 1'b1;
                e.st_addr        = a;
                e.st_data        = f_merge(dr, inst);
                ref_mem[a[9:0]]  = e.st_data;
                e.lat            = 4;
            end
            e.dr = dr;
            if (!check_lat) e.lat = 0;
            exp_q.push_back(e);
            pc = f_next(pc, inst);
        end
    endtask

    // Entered and left in reset, at posedge+1.
    task automatic run_prog(input int n, input bit waits, input bit check_lat);
        int cyc;
        wait_mode = waits;
        hold      = 1'b0;
        ready_ovr = 1'b0;
        build_expect(n, check_lat);
        reset = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40 * n + 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL run_timeout: %0d commits outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end else begin
`ifdef RV_MEM_SEQ_INSTRET_EN
            chk("instret_count", instret, 64'(n));
`endif
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 1024; i++) mem[i] = NOP_INST;
    endtask

    initial begin
        int viol;
        fill_nop();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_commit", 64'(core_commit), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc", 64'(core_pc), 64'd0);
        chk("rst_ir", 64'(core_inst), 64'd0);
        chk("rst_dr", 64'(core_ram_load_value), 64'd0);

        // addi, sb to 0x100, lw from 0x100, then nops: zero-wait with latency checks.
        fill_nop();
        mem[0]    = 32'h00500093;
        mem[1]    = 32'h10200023;
        mem[2]    = 32'h10002183;
        mem[32'h40] = 32'hAABBCCDD;
        run_prog(10, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 1024; i++) mem[i] = rand_inst();
            run_prog(60, (r % 2) == 0, (r % 2) != 0);
        end

        // Halt in EXEC, stay quiet, reset recovers to pc 0.
        fill_nop();
        mem[0] = HALT_INST;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("fetch_req", 64'(mem_req), 64'd1);
        chk("fetch_addr", 64'(mem_addr), 64'd0);
        chk("fetch_we", 64'(mem_we), 64'd0);
        @(posedge clock); #1;
        chk("halt_no_commit", 64'(core_commit), 64'd0);
        @(posedge clock); #1;
        chk("halted_set", 64'(halted), 64'd1);
        viol = 0;
        repeat (100) begin
            @(negedge clock);
            if (mem_req !== 1'b0 || core_commit !== 1'b0 || halted !== 1'b1) viol++;
        end
        chk("halt_quiet", 64'(viol), 64'd0);
        @(posedge clock); #1;
        mem[0] = NOP_INST;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("halt_cleared", 64'(halted), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("resume_req", 64'(mem_req), 64'd1);
        chk("resume_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Load retires, second load is abandoned by reset mid-DATA_RD; late ready must be ignored.
        fill_nop();
        mem[0]      = 32'h10002183;
        mem[1]      = 32'h10402183;
        mem[32'h40] = 32'hAABBCCDD;
        mem[32'h41] = 32'h11223344;
        wait_mode = 1'b0;
        build_expect(1, 1'b1);
        reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        hold = 1'b1;
        @(posedge clock); #1;
        chk("first_load_retired", 64'(exp_q.size()), 64'd0);
        chk("rd_req", 64'(mem_req), 64'd1);
        chk("rd_addr", 64'(mem_addr), 64'h41);
        chk("rd_pc", 64'(core_pc), 64'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        ready_ovr = 1'b1;
        reset = 1'b1;
        chk("post_rst_req", 64'(mem_req), 64'd0);
        chk("abandon_pc", 64'(core_pc), 64'd0);
        chk("abandon_dr", 64'(core_ram_load_value), 64'd0);
        @(posedge clock); #1;
        ready_ovr = 1'b0;
        hold = 1'b0;
        chk("late_ready_ir", 64'(core_inst), 64'd0);
        chk("refetch_req", 64'(mem_req), 64'd1);
        chk("refetch_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

`ifdef RV_MEM_SEQ_INSTRET_EN
        fill_nop();
        build_expect(1, 1'b1);
        reset = 1'b1;
        force dut.instret = '1;
        @(posedge clock); #1;
        release dut.instret;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("instret_wrap", instret, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        exp_q.delete();
`endif

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
